// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, NOP encoding and fetch state encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // One buffer entry is {pc, instruction word}
    localparam int unsigned FETCH_ENTRY_W = 64;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    // Instruction addresses are word aligned; the two low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer of {pc, instr} entries with push, pop and clear.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [FETCH_ENTRY_W-1:0] push_data,
    input  logic                     pop,
    output logic [FETCH_ENTRY_W-1:0] head_data,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         count
);

    logic [FETCH_ENTRY_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         rd_ptr_reg;
    logic [CNT_W-1:0]         count_reg;
    logic [DEPTH-1:0]         wr_en;
    logic                     do_push;
    logic                     do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push while full is only legal when the head leaves in the same cycle.
    assign do_push = push && !clear && (!full || pop);
    assign do_pop  = pop && !empty && !clear;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Entry storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    // Pointers and occupancy; clear wins over a same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests to imem, response buffering,
// decoder handshake and PC redirect with flush of an in-flight response.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e              state_reg, state_next;
    logic [31:0]               pc_reg, pc_next;
    logic                      pending_reg, pending_next;
    logic [31:0]               pend_addr_reg;
    logic                      fire;
    logic                      credit_ok;
    logic                      fifo_push, fifo_pop, fifo_clear;
    logic                      fifo_full, fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic [FETCH_ENTRY_W-1:0]  fifo_head;

    // Responses are exactly one cycle behind the grant, so at most one is in
    // flight; counting it against the buffer keeps pushes from overflowing.
    assign credit_ok = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, pending_reg})
                       < (CNT_W + 1)'(DEPTH);

    // Next-state, request and buffer control; redirect overrides everything.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        pending_next = 1'b0;
        imem_req     = 1'b0;
        fire         = 1'b0;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        fifo_clear   = 1'b0;
        case (state_reg)
            ST_RUN: begin
                imem_req     = rst_n && credit_ok;
                fire         = imem_req && imem_gnt;
                pending_next = fire;
                fifo_push    = pending_reg && imem_rvalid && !fifo_full;
                if (fire) begin
                    pc_next = pc_reg + 32'd4;
                end
                if (redirect_valid && (pending_reg || fire)) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Any response arriving here belongs to the old stream.
                pending_next = pending_reg && !imem_rvalid;
                if (!pending_next) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
        fifo_pop = instr_valid && instr_ready;
        if (redirect_valid) begin
            pc_next    = word_align(redirect_pc);
            fifo_clear = 1'b1;
            fifo_push  = 1'b0;
            fifo_pop   = 1'b0;
        end
    end

    // State, PC and in-flight tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RUN;
            pc_reg        <= RESET_PC;
            pending_reg   <= 1'b0;
            pend_addr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            pending_reg <= pending_next;
            if (fire) begin
                pend_addr_reg <= pc_reg;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data ({pend_addr_reg, imem_rdata}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign imem_addr   = pc_reg;
    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? 32'h0 : fifo_head[31:0];
    assign instr_pc    = fifo_empty ? 32'h0 : fifo_head[63:32];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-side imem model plus a scoreboard
// of expected {pc, instr} pushed at grant time and popped at decoder accept.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_fetch;
    logic        pend_b;
    logic [31:0] pend_addr;
    logic        last_fire;
    logic [31:0] last_fire_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick(input logic gnt, input logic rdy, input logic redir,
                        input logic [31:0] tgt, input logic spur);
        exp_t e;
        logic fire;
        imem_rvalid    = pend_b | spur;
        imem_rdata     = pend_b ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        imem_gnt       = gnt;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        fire = imem_req && gnt;
        if (fire) begin
            check_val("fetch_addr", imem_addr, exp_fetch);
            e.pc   = exp_fetch;
            e.word = mem_word(exp_fetch);
            sb_q.push_back(e);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (instr_valid && rdy && !redir) begin
            check_val("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                $display("pop pc=%h instr=%h (exp pc=%h instr=%h)", instr_pc, instr, e.pc, e.word);
                check_val("instr_pc", instr_pc, e.pc);
                check_val("instr", instr, e.word);
            end
        end
        if (redir) begin
            sb_q.delete();
            exp_fetch = tgt & 32'hFFFF_FFFC;
        end
        pend_b         = fire;
        pend_addr      = imem_addr;
        last_fire      = fire;
        last_fire_addr = imem_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_req", {31'b0, imem_req}, 32'd0);
        check_val("rst_valid", {31'b0, instr_valid}, 32'd0);
        check_val("rst_addr", imem_addr, 32'h0);
        check_val("rst_instr", instr, 32'h0);
        check_val("rst_instr_pc", instr_pc, 32'h0);
        rst_n = 1'b1;
        sb_q.delete();
        exp_fetch = 32'h0;
        pend_b    = 1'b0;
        pend_addr = 32'h0;
        #1;
        check_val("first_req", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        logic found;

        // Streaming with gnt and ready always high
        do_reset();
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        check_val("lat_valid", {31'b0, instr_valid}, 32'd1);
        check_val("lat_pc", instr_pc, 32'h0);
        repeat (20) tick(1, 1, 0, 0, 0);
        repeat (4) tick(0, 1, 0, 0, 0);
        check_val("stream_drained", sb_q.size(), 32'd0);

        // Decoder stalled: buffer fills to two entries and holds its head
        do_reset();
        repeat (6) tick(1, 0, 0, 0, 0);
        check_val("full_req", {31'b0, imem_req}, 32'd0);
        check_val("full_valid", {31'b0, instr_valid}, 32'd1);
        check_val("full_pc", instr_pc, 32'h0);
        check_val("full_instr", instr, mem_word(32'h0));
        repeat (3) tick(1, 0, 0, 0, 0);
        check_val("hold_pc", instr_pc, 32'h0);
        check_val("hold_instr", instr, mem_word(32'h0));
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        check_val("two_only", {31'b0, instr_valid}, 32'd0);
        tick(0, 0, 0, 0, 1);
        check_val("spur_ignored", {31'b0, instr_valid}, 32'd0);

        // Grant withheld: request and address stay put
        do_reset();
        tick(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check_val("stall_req", {31'b0, imem_req}, 32'd1);
            check_val("stall_addr", imem_addr, 32'h4);
            tick(0, 1, 0, 0, 0);
        end
        repeat (8) tick(1, 1, 0, 0, 0);

        // Redirect the cycle after the grant at 0x8
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1, 1, 0, 0, 0);
            found = last_fire && (last_fire_addr == 32'h8);
        end
        check_val("find_gnt8", {31'b0, found}, 32'd1);
        tick(1, 1, 1, 32'h100, 0);
        check_val("redir_valid", {31'b0, instr_valid}, 32'd0);
        check_val("flush_req", {31'b0, imem_req}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (instr_valid) found = 1'b1;
            else tick(1, 0, 0, 0, 0);
        end
        check_val("redir_seen", {31'b0, found}, 32'd1);
        check_val("redir_first_pc", instr_pc, 32'h100);
        repeat (10) tick(1, 1, 0, 0, 0);
        repeat (4) tick(0, 1, 0, 0, 0);
        check_val("redir_drained", sb_q.size(), 32'd0);

        // Idle redirect with unaligned target, then PC wrap at the top
        do_reset();
        tick(0, 1, 1, 32'hFFFF_FFF7, 0);
        check_val("redir_align", imem_addr, 32'hFFFF_FFF4);
        check_val("redir_run_req", {31'b0, imem_req}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1, 1, 0, 0, 0);
            found = last_fire && (last_fire_addr == 32'hFFFF_FFFC);
        end
        check_val("find_top", {31'b0, found}, 32'd1);
        check_val("wrap_addr", imem_addr, 32'h0);
        repeat (10) tick(1, 1, 0, 0, 0);
        repeat (4) tick(0, 1, 0, 0, 0);
        check_val("wrap_drained", sb_q.size(), 32'd0);

        // Asynchronous reset while the buffer holds two entries
        do_reset();
        repeat (6) tick(1, 0, 0, 0, 0);
        check_val("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("async_valid", {31'b0, instr_valid}, 32'd0);
        check_val("async_addr", imem_addr, 32'h0);
        check_val("async_req", {31'b0, imem_req}, 32'd0);
        check_val("async_instr", instr, 32'h0);
        @(negedge clk);
        do_reset();
        repeat (8) tick(1, 1, 0, 0, 0);
        repeat (4) tick(0, 1, 0, 0, 0);
        check_val("restart_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
